// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module      : traffic_light_monitor
// Description : Passive checker for a four-head, two-direction traffic light
//               controller. Registers the twelve lamps, decodes a phase and
//               checks lamp legality, direction conflicts, phase order and
//               phase durations. Reports sticky fault flags and a saturating
//               error count. Duration checks are built only when the macro
//               TLM_DUR_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
    parameter int T_GA = 8,
    parameter int T_AY = 3,
    parameter int T_GB = 6,
    parameter int T_BY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       r1, r2, r3, r4,
    input  logic       y1, y2, y3, y4,
    input  logic       g1, g2, g3, g4,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       synced,
    output logic [3:0] dwell,
    output logic       lamp_err,
    output logic       conflict_err,
    output logic       seq_err,
    output logic       dur_err,
    output logic       fault,
    output logic [7:0] err_count
);

`ifdef TLM_DUR_CHECK_EN
    localparam logic c_dur_en = 1'b1;
`else
    localparam logic c_dur_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        PH_A_GREEN  = 2'd0,
        PH_A_YELLOW = 2'd1,
        PH_B_GREEN  = 2'd2,
        PH_B_YELLOW = 2'd3
    } phase_t;

    // Per-head lamp codes, ordered {red, yellow, green}
    localparam logic [2:0] c_red = 3'b100;
    localparam logic [2:0] c_yel = 3'b010;
    localparam logic [2:0] c_grn = 3'b001;

    logic [11:0] r_samp;
    logic        r_samp_vld;
    phase_t      r_phase;
    logic        r_pv, r_sync, r_seen;
    logic [3:0]  r_dwell;
    logic        r_lamp, r_conf, r_seq, r_dur;
    logic [7:0]  r_cnt;

    logic [2:0]  w_h1, w_h2, w_h3, w_h4;
    logic        w_lamp_bad, w_conf_bad, w_valid;
    phase_t      w_ph;
    logic [4:0]  w_t_cur;
    phase_t      w_nphase;
    logic [3:0]  w_ndwell;
    logic        w_nsync, w_nseen;
    logic        w_lamp_evt, w_conf_evt, w_seq_evt, w_dur_evt, w_any_evt;

    function automatic logic onehot3(input logic [2:0] h);
        return (h == c_red) || (h == c_yel) || (h == c_grn);
    endfunction

    function automatic logic [4:0] t_of(input phase_t p);
        case (p)
            PH_A_GREEN:  return T_GA[4:0];
            PH_A_YELLOW: return T_AY[4:0];
            PH_B_GREEN:  return T_GB[4:0];
            default:     return T_BY[4:0];
        endcase
    endfunction

    // Stage 1: capture every lamp each cycle; r_samp_vld keeps the reset value of the sample from being judged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp     <= '0;
            r_samp_vld <= 1'b0;
        end else begin
            r_samp     <= {r1, y1, g1, r2, y2, g2, r3, y3, g3, r4, y4, g4};
            r_samp_vld <= 1'b1;
        end
    end

    assign w_h1 = r_samp[11:9];
    assign w_h2 = r_samp[8:6];
    assign w_h3 = r_samp[5:3];
    assign w_h4 = r_samp[2:0];

    // Decode the sample into lamp/conflict conditions and a phase; all-red is well formed but names no phase
    always_comb begin
        w_lamp_bad = !(onehot3(w_h1) && onehot3(w_h2) && onehot3(w_h3) && onehot3(w_h4))
                     || (w_h1 != w_h2) || (w_h3 != w_h4);
        w_conf_bad = !(r_samp[11] && r_samp[8]) && !(r_samp[5] && r_samp[2]);
        w_valid    = 1'b0;
        w_ph       = PH_A_GREEN;
        if (!w_lamp_bad) begin
            if (w_h1 == c_red && w_h3 == c_grn) begin
                w_valid = 1'b1;
                w_ph    = PH_B_GREEN;
            end else if (w_h1 == c_red && w_h3 == c_yel) begin
                w_valid = 1'b1;
                w_ph    = PH_B_YELLOW;
            end else if (w_h3 == c_red && w_h1 == c_grn) begin
                w_valid = 1'b1;
                w_ph    = PH_A_GREEN;
            end else if (w_h3 == c_red && w_h1 == c_yel) begin
                w_valid = 1'b1;
                w_ph    = PH_A_YELLOW;
            end
        end
    end

    assign w_t_cur = t_of(r_phase);

    // Phase tracking: dwell counting, sequence and duration checks, event generation
    always_comb begin
        w_nphase   = r_phase;
        w_ndwell   = r_dwell;
        w_nsync    = r_sync;
        w_nseen    = r_seen;
        w_lamp_evt = 1'b0;
        w_conf_evt = 1'b0;
        w_seq_evt  = 1'b0;
        w_dur_evt  = 1'b0;
        if (r_samp_vld) begin
            w_lamp_evt = w_lamp_bad;
            w_conf_evt = w_conf_bad;
            if (!w_valid) begin
                w_nsync  = 1'b0;
                w_ndwell = 4'd0;
            end else if (!r_seen) begin
                // First legal phase after reset may have been joined mid-way: just latch it
                w_nphase = w_ph;
                w_ndwell = 4'd1;
                w_nseen  = 1'b1;
            end else if (w_ph == r_phase) begin
                if (r_dwell != 4'd15) begin
                    w_ndwell = r_dwell + 4'd1;
                end
                // Overlong: dwell is about to step from T to T+1 (fires once per occurrence)
                if (c_dur_en && r_sync && ({1'b0, r_dwell} == w_t_cur) && (r_dwell != 4'd15)) begin
                    w_dur_evt = 1'b1;
                end
            end else begin
                w_nphase = w_ph;
                w_ndwell = 4'd1;
                if (r_sync) begin
                    if (w_ph != phase_t'(r_phase + 2'd1)) begin
                        w_seq_evt = 1'b1;
                        w_nsync   = 1'b0;
                    end else if (c_dur_en && ({1'b0, r_dwell} < w_t_cur)) begin
                        // Too long was already reported while the phase ran; only short remains here
                        w_dur_evt = 1'b1;
                    end
                end else begin
                    w_nsync = 1'b1;
                end
            end
        end
        w_any_evt = w_lamp_evt || w_conf_evt || w_seq_evt || w_dur_evt;
    end

    // Tracking state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= PH_A_GREEN;
            r_pv    <= 1'b0;
            r_sync  <= 1'b0;
            r_seen  <= 1'b0;
            r_dwell <= 4'd0;
        end else begin
            r_phase <= w_nphase;
            r_pv    <= r_samp_vld && w_valid;
            r_sync  <= w_nsync;
            r_seen  <= w_nseen;
            r_dwell <= w_ndwell;
        end
    end

    // Sticky flags and saturating error count; a same-cycle event beats clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lamp <= 1'b0;
            r_conf <= 1'b0;
            r_seq  <= 1'b0;
            r_dur  <= 1'b0;
            r_cnt  <= 8'd0;
        end else begin
            r_lamp <= w_lamp_evt || (r_lamp && !clr);
            r_conf <= w_conf_evt || (r_conf && !clr);
            r_seq  <= w_seq_evt  || (r_seq  && !clr);
            r_dur  <= w_dur_evt  || (r_dur  && !clr);
            if (w_any_evt) begin
                if (clr) begin
                    r_cnt <= 8'd1;
                end else if (r_cnt != 8'd255) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else if (clr) begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign phase        = r_phase;
    assign phase_valid  = r_pv;
    assign synced       = r_sync;
    assign dwell        = r_dwell;
    assign lamp_err     = r_lamp;
    assign conflict_err = r_conf;
    assign seq_err      = r_seq;
    assign dur_err      = r_dur;
    assign fault        = r_lamp || r_conf || r_seq || r_dur;
    assign err_count    = r_cnt;

endmodule

`default_nettype wire
